xor_frame_parity: RTL and testbench
===================================

// Module: xor_frame_parity
// PURPOSE
//   Parametrised, streaming successor to the 2-input XOR gate: bitwise XOR-reduces a
//   frame of FRAME_LEN words of WIDTH bits into one parity word.
//   Two modes: generate (emit parity) and check (the last word is the expected parity;
//   flag a mismatch). Keeps frame and error statistics.
//   Sits between a word source and a consumer, using valid/ready on both sides.
// PARAMETERS
//   WIDTH      8   data/parity word width, >=1
//   FRAME_LEN  4   words per frame, >=2
//   ODD        0   0: even parity; 1: odd parity (result inverted bitwise)
//   ERR_CNT_W  8   width of the saturating error counter
//   FRM_CNT_W  16  width of the wrapping frame counter
// PORTS
//   clk         in   1          single clock; all state on the rising edge
//   rst_n       in   1          asynchronous, active-low reset
//   in_valid    in   1          in_data is valid
//   in_ready    out  1          block accepts a word when in_valid&in_ready
//   in_data     in   WIDTH      input word
//   mode_check  in   1          0: generate, 1: check; sampled with the frame's first word
//   out_valid   out  1          result is valid
//   out_ready   in   1          consumer takes the result when out_valid&out_ready
//   out_parity  out  WIDTH      frame XOR ^ {WIDTH{ODD}}
//   out_err     out  1          check mode: |out_parity; generate mode: always 0
//   err_cnt     out  ERR_CNT_W  count of delivered frames with out_err=1; saturates at max
//   frame_cnt   out  FRM_CNT_W  count of delivered frames; wraps to 0
// BEHAVIOUR
//   - Reset (async assert, sync release): state=ACCUM, acc=0, word count=0. Outputs:
//     in_ready=0 while rst_n=0, out_valid=0, out_parity=0, out_err=0, err_cnt=0,
//     frame_cnt=0.
//   - FSM has two states.
//     - ACCUM: in_ready=1, out_valid=0.
//       - On each accepted word: acc<=acc^in_data and count++.
//       - On the first word (count==0), latch mode_check.
//       - On the word with count==FRAME_LEN-1:
//         - register out_parity<=(acc^in_data)^{WIDTH{ODD}};
//         - register out_err<=latched_mode & |that value;
//         - go to HOLD.
//     - HOLD: in_ready=0, out_valid=1, outputs registered and stable.
//       - On out_ready: frame_cnt++ (wraps), err_cnt++ if out_err (holds at
//         2^ERR_CNT_W-1), acc<=0, count<=0, go to ACCUM.
//       - out_valid deasserts the cycle after that handshake.
//   - Latency: out_valid rises the cycle after the last word is accepted. The next frame's
//     first word is accepted no earlier than the cycle after the output handshake.
//     Throughput is therefore FRAME_LEN+1 cycles per frame at best.
//   - Gaps: in_valid=0 cycles in ACCUM leave acc and count unchanged.
//   - in_data and in_valid are ignored in HOLD. mode_check is ignored except on the first word.
//   - out_parity and out_err keep their last value after the handshake, but are only
//     meaningful while out_valid=1.
//   - Reset mid-frame or in HOLD discards the partial frame and any pending result.
//     Counters clear too.
//   - Width rules: all XORs are WIDTH wide with no extension. Counters never overflow
//     into other fields.
// TESTING
//   Defaults unless noted: WIDTH=8, FRAME_LEN=4.
//   1. Reset: hold rst_n=0, toggle inputs -> in_ready=0, out_valid=0, out_parity=0x00,
//      err_cnt=0, frame_cnt=0. Release -> in_ready=1 on the next edge.
//   2. Generate: words 0x01,0x02,0x04,0x08 on back-to-back cycles, mode_check=0
//      -> one cycle later out_valid=1, out_parity=0x0F, out_err=0.
//      After the handshake, frame_cnt=1.
//   3. Check: 0x12,0x34,0x56,0x70 with mode_check=1 -> out_parity=0x00, out_err=0.
//      Repeat with last word 0x71 -> out_parity=0x01, out_err=1, err_cnt=1 after the
//      handshake.
//   4. Backpressure and gaps:
//      - in_valid toggled 1/0 within a frame -> result equals the gap-free result.
//      - out_ready=0 for 5 cycles in HOLD -> out_valid and out_parity stable, in_ready=0,
//        extra in_valid words not absorbed.
//   5. ODD=1: words 0x01,0x02,0x04,0x08 -> out_parity=0xF0.
//      mode_check toggled mid-frame -> the mode latched at the first word is used.
//   6. Boundaries:
//      - rst_n pulsed after 2 words -> the next 4 words alone form the frame.
//      - 300 failing check frames -> err_cnt saturates at 0xFF.
//      - 65537 frames -> frame_cnt=1.

Source files
------------

// File: rtl/xor_frame_parity.sv
// Streaming XOR-parity over fixed-length frames, with generate/check modes.
// Keeps a wrapping delivered-frame counter and a saturating error counter.
module xor_frame_parity #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned ODD       = 0,
   parameter int unsigned ERR_CNT_W = 8,
   parameter int unsigned FRM_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 mode_check,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_parity,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [FRM_CNT_W-1:0] frame_cnt
);

   localparam int unsigned        CNT_W    = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0]   LAST     = CNT_W'(FRAME_LEN - 1);
   localparam logic [WIDTH-1:0]   ODD_MASK = {WIDTH{ODD != 0}};

   typedef enum logic {S_ACCUM, S_HOLD} state_t;

   state_t                 r_state;
   logic [WIDTH-1:0]       r_acc;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_mode;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [WIDTH-1:0]       r_parity;
   logic                   r_err;
   logic [ERR_CNT_W-1:0]   r_err_cnt;
   logic [FRM_CNT_W-1:0]   r_frm_cnt;

   logic                   w_accept;
   logic [WIDTH-1:0]       w_next;
   logic [WIDTH-1:0]       w_par;

   // in_ready is only ever high in ACCUM, so it alone qualifies acceptance
   assign w_accept = in_valid & r_in_ready;
   assign w_next   = r_acc ^ in_data;
   assign w_par    = w_next ^ ODD_MASK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_ACCUM;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_parity    <= '0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
         r_frm_cnt   <= '0;
      end else begin
         case (r_state)
            S_ACCUM: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_acc <= w_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == '0) r_mode <= mode_check;
                  if (r_cnt == LAST) begin
                     r_parity    <= w_par;
                     r_err       <= r_mode & (|w_par);
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_frm_cnt <= r_frm_cnt + FRM_CNT_W'(1);
                  if (r_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_ACCUM;
               end
            end
            default: r_state <= S_ACCUM;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_parity = r_parity;
   assign out_err    = r_err;
   assign err_cnt    = r_err_cnt;
   assign frame_cnt  = r_frm_cnt;

endmodule

// File: tb/tb_xor_frame_parity.sv
// Directed bench for xor_frame_parity: even and odd instances share stimulus,
// a short-counter instance exercises frame counter wrap.
module tb_xor_frame_parity;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, mode_check = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;

   logic       in_ready, out_valid, out_err;
   logic [7:0] out_parity, err_cnt;
   logic [15:0] frame_cnt;
   logic       in_ready_o, out_valid_o, out_err_o;
   logic [7:0] out_parity_o, err_cnt_o;
   logic [15:0] frame_cnt_o;

   logic       wv = 1'b0, wm = 1'b0, wr = 1'b0;
   logic [7:0] wd = '0;
   logic       wir, wov, werr;
   logic [7:0] wpar, wec;
   logic [3:0] wfc;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned exp_frm = 0, exp_err = 0, exp_err_o = 0;

   always #5 clk = ~clk;

   xor_frame_parity #(.WIDTH(8), .FRAME_LEN(4), .ODD(0), .ERR_CNT_W(8), .FRM_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mode_check(mode_check), .out_valid(out_valid), .out_ready(out_ready),
      .out_parity(out_parity), .out_err(out_err), .err_cnt(err_cnt), .frame_cnt(frame_cnt));

   xor_frame_parity #(.WIDTH(8), .FRAME_LEN(4), .ODD(1), .ERR_CNT_W(8), .FRM_CNT_W(16)) dut_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o), .in_data(in_data),
      .mode_check(mode_check), .out_valid(out_valid_o), .out_ready(out_ready),
      .out_parity(out_parity_o), .out_err(out_err_o), .err_cnt(err_cnt_o), .frame_cnt(frame_cnt_o));

   xor_frame_parity #(.WIDTH(8), .FRAME_LEN(2), .ODD(0), .ERR_CNT_W(8), .FRM_CNT_W(4)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(wv), .in_ready(wir), .in_data(wd),
      .mode_check(wm), .out_valid(wov), .out_ready(wr),
      .out_parity(wpar), .out_err(werr), .err_cnt(wec), .frame_cnt(wfc));

   typedef struct {
      string             name;
      logic [3:0][7:0]   w;
      logic [3:0]        m;
      logic [7:0]        par;
      logic              err;
      logic [7:0]        par_o;
      logic              err_o;
      logic              gap;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic m);
      int unsigned n = 0;
      in_valid = 1'b1; in_data = d; mode_check = m;
      while (!in_ready && n < 20) begin tick(); n++; end
      chk("in_ready_wait", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic take(input logic e, input logic eo);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_frm = (exp_frm + 1) % 65536;
      if (e  && exp_err   < 255) exp_err++;
      if (eo && exp_err_o < 255) exp_err_o++;
      chk("valid_after_hs", out_valid, 0);
      chk("in_ready_after_hs", in_ready, 1);
      chk("frame_cnt", frame_cnt, exp_frm);
      chk("err_cnt", err_cnt, exp_err);
      chk("frame_cnt_odd", frame_cnt_o, exp_frm);
      chk("err_cnt_odd", err_cnt_o, exp_err_o);
   endtask

   task automatic run_frame(input string name, input logic [3:0][7:0] w, input logic [3:0] m,
                            input logic [7:0] par, input logic err,
                            input logic [7:0] par_o, input logic err_o, input logic gap);
      for (int i = 0; i < 4; i++) begin
         send(w[i], m[i]);
         if (gap && i < 3) tick();
      end
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_in_ready"}, in_ready, 0);
      chk({name, "_parity"}, out_parity, par);
      chk({name, "_err"}, out_err, err);
      chk({name, "_parity_odd"}, out_parity_o, par_o);
      chk({name, "_err_odd"}, out_err_o, err_o);
      take(err, err_o);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[8];
      // words listed last-to-first: w[0] is sent first
      vecs[0] = '{"gen",      {8'h08, 8'h04, 8'h02, 8'h01}, 4'b0000, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0};
      vecs[1] = '{"chk_ok",   {8'h70, 8'h56, 8'h34, 8'h12}, 4'b1111, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{"chk_bad",  {8'h71, 8'h56, 8'h34, 8'h12}, 4'b1111, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
      vecs[3] = '{"allones",  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{"mixed",    {8'h0F, 8'h00, 8'h5A, 8'hA5}, 4'b1111, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b0};
      vecs[5] = '{"gaps",     {8'h88, 8'h44, 8'h22, 8'h11}, 4'b0000, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{"mode_1st", {8'h71, 8'h56, 8'h34, 8'h12}, 4'b0001, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
      vecs[7] = '{"mode_0th", {8'h71, 8'h56, 8'h34, 8'h12}, 4'b1110, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};

      // reset held with inputs wiggling
      for (int i = 0; i < 4; i++) begin
         in_valid = i[0]; in_data = 8'(i * 37 + 5); out_ready = ~i[0]; mode_check = i[1];
         tick();
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
      end
      chk("rst_parity", out_parity, 8'h00);
      chk("rst_err", out_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      in_valid = 1'b0; out_ready = 1'b0; mode_check = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("release_in_ready", in_ready, 1);

      foreach (vecs[k])
         run_frame(vecs[k].name, vecs[k].w, vecs[k].m, vecs[k].par, vecs[k].err,
                   vecs[k].par_o, vecs[k].err_o, vecs[k].gap);

      // output backpressure: result held, extra words refused
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0); send(8'h08, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'hAA;
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_parity", out_parity, 8'h0F);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      take(1'b0, 1'b0);
      run_frame("after_bp", {8'h08, 8'h04, 8'h02, 8'h01}, 4'b0000, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0);

      // reset mid-frame discards partial accumulation and counters
      send(8'h03, 1'b1); send(8'h05, 1'b1);
      rst_n = 1'b0;
      #2;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      tick();
      rst_n = 1'b1;
      exp_frm = 0; exp_err = 0; exp_err_o = 0;
      tick();
      run_frame("post_rst", {8'h08, 8'h04, 8'h02, 8'h01}, 4'b0000, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0);
      chk("post_rst_frame_cnt", frame_cnt, 1);

      // error counter saturation
      for (int f = 0; f < 300; f++)
         run_frame("sat", {8'h01, 8'h00, 8'h00, 8'h00}, 4'b1111, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0);
      chk("err_cnt_saturated", err_cnt, 8'hFF);
      chk("err_cnt_odd_saturated", err_cnt_o, 8'hFF);
      chk("frame_cnt_301", frame_cnt, 301);

      // frame counter wrap on the 4-bit counter instance (2^4 + 1 frames)
      for (int f = 0; f < 17; f++) begin
         for (int i = 0; i < 2; i++) begin
            int unsigned n = 0;
            wv = 1'b1; wd = (i == 0) ? 8'(f) : 8'h5A; wm = 1'b0;
            while (!wir && n < 20) begin tick(); n++; end
            chk("wrap_in_ready", wir, 1);
            tick();
            wv = 1'b0;
         end
         chk("wrap_valid", wov, 1);
         chk("wrap_parity", wpar, 8'(f) ^ 8'h5A);
         wr = 1'b1;
         tick();
         wr = 1'b0;
         chk("wrap_frame_cnt", wfc, (f + 1) % 16);
      end
      chk("wrap_final", wfc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
